// File: rtl/axi2mem_pkg.sv
// -----------------------------------------------------------------------------
// axi2mem_pkg
// Shared types for the axi2mem write-address path:
//   burst_t            AXI burst encoding (FIXED / INCR / WRAP)
//   state_t            unroller FSM state
//   aw_cmd_t           one buffered AW burst (id, start address, len, size, burst)
//   BURST_WRAP_LEN_OK  bit n set when len==n is a legal WRAP length (2/4/8/16 beats)
//   wrap_len_ok()      lookup into BURST_WRAP_LEN_OK
// aw_cmd_t field widths follow CMD_ID_W / CMD_ADDR_W, which are the defaults of
// the top-level AXI_ID_WIDTH / AXI_ADDR_WIDTH parameters.
// -----------------------------------------------------------------------------
package axi2mem_pkg;

    localparam int unsigned CMD_ID_W   = 6;
    localparam int unsigned CMD_ADDR_W = 32;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [CMD_ID_W-1:0]   id;
        logic [CMD_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        burst_t                burst;
    } aw_cmd_t;

    // Bits 1, 3, 7 and 15 set.
    localparam logic [15:0] BURST_WRAP_LEN_OK = 16'h808A;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len[7:4] == 4'd0) && BURST_WRAP_LEN_OK[len[3:0]];
    endfunction

endpackage

// File: rtl/axi2mem_cmd_fifo.sv
// -----------------------------------------------------------------------------
// axi2mem_cmd_fifo
// Synchronous FIFO of aw_cmd_t entries, DEPTH entries (power of two, >= 2).
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (empties the FIFO)
//   push_i, data_i write one entry (ignored when full)
//   pop_i          drop the head entry (ignored when empty)
//   head_o         current head entry (valid when !empty_o)
//   full_o,empty_o occupancy flags
// -----------------------------------------------------------------------------
module axi2mem_cmd_fifo
    import axi2mem_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  aw_cmd_t data_i,
    input  logic    pop_i,
    output aw_cmd_t head_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    aw_cmd_t          mem [DEPTH];
    // One extra wrap bit distinguishes full from empty when the indices match.
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_o  = mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i && !empty_o)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o)
            mem[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end

endmodule

// File: rtl/axi2mem_wr_cmd_unroll.sv
// -----------------------------------------------------------------------------
// axi2mem_wr_cmd_unroll
// Write-address stage of axi2mem: buffers AXI AW bursts and unrolls each one
// into per-beat word commands on the trans_* request/grant handshake.
// Beat n of a burst is only presented after beat n-1 has been granted.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   aw_*_i, aw_ready_o  AXI AW channel (id, addr, len, size, burst, valid/ready)
//   trans_id_o          id of the current beat
//   trans_add_o         word-aligned byte address of the current beat
//   trans_last_o        current beat is the last of its burst
//   trans_req_o         beat command valid; trans_gnt_i consumes it
//   size_err_o          one-cycle pulse the cycle after an AW with size > 2
//   busy_o              buffered bursts pending or a burst in progress
// Configuration macro: AXI2MEM_WRAP_EN
//   defined     WRAP bursts wrap at the (len+1)<<size boundary
//   undefined   WRAP bursts run as INCR and also raise size_err_o
// -----------------------------------------------------------------------------
module axi2mem_wr_cmd_unroll
    import axi2mem_pkg::*;
#(
    parameter int unsigned AXI_ID_WIDTH   = CMD_ID_W,
    parameter int unsigned AXI_ADDR_WIDTH = CMD_ADDR_W,
    parameter int unsigned CMD_FIFO_DEPTH = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [AXI_ID_WIDTH-1:0]   aw_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]                aw_len_i,
    input  logic [2:0]                aw_size_i,
    input  logic [1:0]                aw_burst_i,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    output logic [AXI_ID_WIDTH-1:0]   trans_id_o,
    output logic [AXI_ADDR_WIDTH-1:0] trans_add_o,
    output logic                      trans_last_o,
    output logic                      trans_req_o,
    input  logic                      trans_gnt_i,
    output logic                      size_err_o,
    output logic                      busy_o
);

    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > 3'd2) ? 3'd2 : size;
    endfunction

`ifdef AXI2MEM_WRAP_EN
    function automatic logic [AXI_ADDR_WIDTH-1:0] wrap_addr(
        input logic [AXI_ADDR_WIDTH-1:0] addr,
        input logic [AXI_ADDR_WIDTH-1:0] incr,
        input logic [7:0]                len,
        input logic [2:0]                size
    );
        logic [AXI_ADDR_WIDTH-1:0] mask;
        mask = ((AXI_ADDR_WIDTH'(len) + 1'b1) << size) - 1'b1;
        return (addr & ~mask) | (incr & mask);
    endfunction
`endif

    aw_cmd_t push_cmd;
    aw_cmd_t head;
    logic    push;
    logic    fifo_full;
    logic    fifo_empty;
    logic    size_bad;

    state_t  state_q;
    state_t  state_d;
    logic    vld_p1;
    logic    load;
    logic    advance;

    logic [AXI_ID_WIDTH-1:0]   cur_id_p1;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr_p1;
    logic [7:0]                cnt_p1;
    logic [2:0]                cur_size_p1;
    burst_t                    cur_burst_p1;
`ifdef AXI2MEM_WRAP_EN
    logic [7:0]                cur_len_p1;
`endif
    logic                      size_err_p1;

    logic [AXI_ADDR_WIDTH-1:0] inc;
    logic [AXI_ADDR_WIDTH-1:0] incr_addr;
    logic [AXI_ADDR_WIDTH-1:0] next_addr;

    // ---- stage p0: AW acceptance into the command FIFO ----
    assign aw_ready_o = !fifo_full;
    assign push       = aw_valid_i && aw_ready_o;

`ifdef AXI2MEM_WRAP_EN
    assign size_bad = (aw_size_i > 3'd2);
`else
    assign size_bad = (aw_size_i > 3'd2) || (aw_burst_i == 2'b10);
`endif

    always_comb begin
        push_cmd      = '0;
        push_cmd.id   = aw_id_i;
        push_cmd.addr = aw_addr_i;
        push_cmd.len  = aw_len_i;
        push_cmd.size = clamp_size(aw_size_i);
        // The reserved encoding 2'b11 is treated as INCR.
        case (aw_burst_i)
            2'b00:   push_cmd.burst = BURST_FIXED;
`ifdef AXI2MEM_WRAP_EN
            2'b10:   push_cmd.burst = BURST_WRAP;
`endif
            default: push_cmd.burst = BURST_INCR;
        endcase
    end

    axi2mem_cmd_fifo #(
        .DEPTH   (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_cmd),
        .pop_i   (load),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ---- stage p1: beat unroller ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            size_err_p1 <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_err_p1 <= push && size_bad;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_RUN;
            ST_RUN:  if (trans_gnt_i && (cnt_p1 == 8'd0) && fifo_empty) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A last-beat grant with a buffered burst reloads in the same edge,
    // so consecutive bursts stream with no idle cycle between them.
    always_comb begin
        vld_p1  = 1'b0;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: load = !fifo_empty;
            ST_RUN: begin
                vld_p1 = 1'b1;
                if (trans_gnt_i) begin
                    if (cnt_p1 == 8'd0) load    = !fifo_empty;
                    else                advance = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Narrow beats align down to their size first, so a word address may
    // repeat for several beats.
    always_comb begin
        inc       = AXI_ADDR_WIDTH'(1) << cur_size_p1;
        incr_addr = (cur_addr_p1 & ~(inc - 1'b1)) + inc;
        next_addr = incr_addr;
        if (cur_burst_p1 == BURST_FIXED)
            next_addr = cur_addr_p1;
`ifdef AXI2MEM_WRAP_EN
        else if (cur_burst_p1 == BURST_WRAP && wrap_len_ok(cur_len_p1))
            next_addr = wrap_addr(cur_addr_p1, incr_addr, cur_len_p1, cur_size_p1);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (load) begin
            cur_id_p1    <= head.id;
            cur_addr_p1  <= head.addr;
            cnt_p1       <= head.len;
            cur_size_p1  <= head.size;
            cur_burst_p1 <= head.burst;
`ifdef AXI2MEM_WRAP_EN
            cur_len_p1   <= head.len;
`endif
        end else if (advance) begin
            cnt_p1      <= cnt_p1 - 8'd1;
            cur_addr_p1 <= next_addr;
        end
    end

    // Beat fields are forced to zero outside RUN so nothing stale is visible.
    assign trans_req_o  = vld_p1;
    assign trans_id_o   = vld_p1 ? cur_id_p1 : '0;
    assign trans_add_o  = vld_p1 ? {cur_addr_p1[AXI_ADDR_WIDTH-1:2], 2'b00} : '0;
    assign trans_last_o = vld_p1 && (cnt_p1 == 8'd0);
    assign size_err_o   = size_err_p1;
    assign busy_o       = !fifo_empty || (state_q == ST_RUN);

endmodule

// File: tb/tb_axi2mem_wr_cmd_unroll.sv
`timescale 1ns/1ps
module tb_axi2mem_wr_cmd_unroll;

    localparam logic [1:0] B_FIXED = 2'b00;
    localparam logic [1:0] B_INCR  = 2'b01;
    localparam logic [1:0] B_WRAP  = 2'b10;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [5:0]  aw_id_i = '0;
    logic [31:0] aw_addr_i = '0;
    logic [7:0]  aw_len_i = '0;
    logic [2:0]  aw_size_i = '0;
    logic [1:0]  aw_burst_i = '0;
    logic        aw_valid_i = 1'b0;
    logic        aw_ready_o;
    logic [5:0]  trans_id_o;
    logic [31:0] trans_add_o;
    logic        trans_last_o;
    logic        trans_req_o;
    logic        trans_gnt_i = 1'b0;
    logic        size_err_o;
    logic        busy_o;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;

    logic [31:0] cap_add [0:31];
    logic [5:0]  cap_id  [0:31];
    logic        cap_last[0:31];
    int          cap_cyc [0:31];
    int          cap_n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    axi2mem_wr_cmd_unroll #(
        .AXI_ID_WIDTH   (6),
        .AXI_ADDR_WIDTH (32),
        .CMD_FIFO_DEPTH (2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .aw_id_i      (aw_id_i),
        .aw_addr_i    (aw_addr_i),
        .aw_len_i     (aw_len_i),
        .aw_size_i    (aw_size_i),
        .aw_burst_i   (aw_burst_i),
        .aw_valid_i   (aw_valid_i),
        .aw_ready_o   (aw_ready_o),
        .trans_id_o   (trans_id_o),
        .trans_add_o  (trans_add_o),
        .trans_last_o (trans_last_o),
        .trans_req_o  (trans_req_o),
        .trans_gnt_i  (trans_gnt_i),
        .size_err_o   (size_err_o),
        .busy_o       (busy_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the accepting edge (cycle 1 relative to the handshake).
    task automatic send_aw(input logic [5:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        int w = 0;
        aw_id_i = id; aw_addr_i = addr; aw_len_i = len;
        aw_size_i = size; aw_burst_i = burst; aw_valid_i = 1'b1;
        while (!aw_ready_o && w < 50) begin cyc(); w++; end
        total++;
        if (aw_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL aw_handshake_timeout: aw_ready_o=%b required 1", aw_ready_o);
        end
        cyc();
        aw_valid_i = 1'b0;
    endtask

    // Records every granted beat; ends one cycle after the n-th grant.
    task automatic collect(input int n, input int budget);
        int b = 0;
        cap_n = 0;
        while (cap_n < n && b < budget) begin
            if (trans_req_o && trans_gnt_i) begin
                cap_add[cap_n]  = trans_add_o;
                cap_id[cap_n]   = trans_id_o;
                cap_last[cap_n] = trans_last_o;
                cap_cyc[cap_n]  = cyc_cnt;
                cap_n++;
            end
            cyc();
            b++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cyc(); cyc();
        rst_i = 1'b0;
        total++;
        if (aw_ready_o !== 1'b1 || trans_req_o !== 1'b0 || busy_o !== 1'b0 ||
            size_err_o !== 1'b0 || trans_last_o !== 1'b0 || trans_add_o !== 32'h0 ||
            trans_id_o !== 6'h0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b req=%b busy=%b err=%b last=%b add=%h id=%h required ready=1 others 0",
                     aw_ready_o, trans_req_o, busy_o, size_err_o, trans_last_o, trans_add_o, trans_id_o);
        end
        trans_gnt_i = 1'b1;
        cyc(); cyc();
        total++;
        if (trans_req_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_gnt_ignored: req=%b busy=%b required 0 0", trans_req_o, busy_o);
        end
    endtask

    task automatic test_incr();
        logic [31:0] exp [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        trans_gnt_i = 1'b1;
        send_aw(6'd5, 32'h1000, 8'd3, 3'd2, B_INCR);
        total++;
        if (trans_req_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL incr_cycle1: req=%b busy=%b required 0 1", trans_req_o, busy_o);
        end
        cyc();
        total++;
        if (trans_req_o !== 1'b1 || trans_add_o !== 32'h1000 || trans_id_o !== 6'd5) begin
            bad++;
            $display("FAIL incr_latency: req=%b add=%h id=%0d required 1 00001000 5",
                     trans_req_o, trans_add_o, trans_id_o);
        end
        collect(4, 20);
        total++;
        if (cap_n !== 4) begin bad++; $display("FAIL incr_count: got %0d beats required 4", cap_n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cap_add[i] !== exp[i] || cap_last[i] !== (i == 3) || cap_id[i] !== 6'd5) begin
                bad++;
                $display("FAIL incr_beat%0d: add=%h last=%b id=%0d required add=%h last=%b id=5",
                         i, cap_add[i], cap_last[i], cap_id[i], exp[i], (i == 3));
            end
        end
        total++;
        if (trans_req_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL incr_drain: req=%b busy=%b required 0 0", trans_req_o, busy_o);
        end
    endtask

    task automatic test_wrap();
`ifdef AXI2MEM_WRAP_EN
        logic [31:0] exp [4] = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
        logic        exp_err = 1'b0;
`else
        logic [31:0] exp [4] = '{32'h1008, 32'h100C, 32'h1010, 32'h1014};
        logic        exp_err = 1'b1;
`endif
        trans_gnt_i = 1'b1;
        send_aw(6'd7, 32'h1008, 8'd3, 3'd2, B_WRAP);
        total++;
        if (size_err_o !== exp_err) begin
            bad++;
            $display("FAIL wrap_size_err: size_err=%b required %b", size_err_o, exp_err);
        end
        collect(4, 20);
        total++;
        if (cap_n !== 4) begin bad++; $display("FAIL wrap_count: got %0d beats required 4", cap_n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cap_add[i] !== exp[i] || cap_last[i] !== (i == 3)) begin
                bad++;
                $display("FAIL wrap_beat%0d: add=%h last=%b required add=%h last=%b",
                         i, cap_add[i], cap_last[i], exp[i], (i == 3));
            end
        end
    endtask

    task automatic test_fixed_and_narrow();
        logic [31:0] exp_n [4] = '{32'h100, 32'h100, 32'h100, 32'h104};
        trans_gnt_i = 1'b1;
        send_aw(6'd3, 32'h20, 8'd2, 3'd2, B_FIXED);
        collect(3, 20);
        total++;
        if (cap_n !== 3) begin bad++; $display("FAIL fixed_count: got %0d beats required 3", cap_n); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (cap_add[i] !== 32'h20 || cap_last[i] !== (i == 2)) begin
                bad++;
                $display("FAIL fixed_beat%0d: add=%h last=%b required add=00000020 last=%b",
                         i, cap_add[i], cap_last[i], (i == 2));
            end
        end
        send_aw(6'd4, 32'h101, 8'd3, 3'd0, B_INCR);
        collect(4, 20);
        total++;
        if (cap_n !== 4) begin bad++; $display("FAIL narrow_count: got %0d beats required 4", cap_n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cap_add[i] !== exp_n[i] || cap_last[i] !== (i == 3)) begin
                bad++;
                $display("FAIL narrow_beat%0d: add=%h last=%b required add=%h last=%b",
                         i, cap_add[i], cap_last[i], exp_n[i], (i == 3));
            end
        end
    endtask

    task automatic test_size_err();
        trans_gnt_i = 1'b1;
        send_aw(6'd9, 32'h40, 8'd1, 3'd3, B_INCR);
        total++;
        if (size_err_o !== 1'b1) begin
            bad++; $display("FAIL size_err_pulse: size_err=%b required 1", size_err_o);
        end
        cyc();
        total++;
        if (size_err_o !== 1'b0 || trans_req_o !== 1'b1) begin
            bad++;
            $display("FAIL size_err_one_cycle: size_err=%b req=%b required 0 1", size_err_o, trans_req_o);
        end
        collect(2, 20);
        total++;
        if (cap_n !== 2 || cap_add[0] !== 32'h40 || cap_add[1] !== 32'h44 || cap_last[1] !== 1'b1) begin
            bad++;
            $display("FAIL size_clamp: n=%0d add0=%h add1=%h last1=%b required 2 00000040 00000044 1",
                     cap_n, cap_add[0], cap_add[1], cap_last[1]);
        end
    endtask

    task automatic test_stall();
        int w = 0;
        trans_gnt_i = 1'b0;
        send_aw(6'd9, 32'h2000, 8'd3, 3'd2, B_INCR);
        while (!trans_req_o && w < 10) begin cyc(); w++; end
        total++;
        if (trans_req_o !== 1'b1 || trans_add_o !== 32'h2000) begin
            bad++;
            $display("FAIL stall_first: req=%b add=%h required 1 00002000", trans_req_o, trans_add_o);
        end
        trans_gnt_i = 1'b1;
        cyc();
        trans_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (trans_req_o !== 1'b1 || trans_add_o !== 32'h2004 || trans_id_o !== 6'd9 ||
                trans_last_o !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d: req=%b add=%h id=%0d last=%b required 1 00002004 9 0",
                         i, trans_req_o, trans_add_o, trans_id_o, trans_last_o);
            end
            cyc();
        end
        trans_gnt_i = 1'b1;
        collect(3, 20);
        total++;
        if (cap_n !== 3 || cap_add[0] !== 32'h2004 || cap_add[1] !== 32'h2008 ||
            cap_add[2] !== 32'h200C || cap_last[2] !== 1'b1 || cap_last[0] !== 1'b0) begin
            bad++;
            $display("FAIL stall_resume: n=%0d adds=%h %h %h last=%b%b required 3 00002004 00002008 0000200c 01",
                     cap_n, cap_add[0], cap_add[1], cap_add[2], cap_last[0], cap_last[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base [3] = '{32'h3000, 32'h4000, 32'h5000};
        trans_gnt_i = 1'b1;
        fork
            begin
                send_aw(6'd1, 32'h3000, 8'd3, 3'd2, B_INCR);
                send_aw(6'd2, 32'h4000, 8'd3, 3'd2, B_INCR);
                send_aw(6'd3, 32'h5000, 8'd3, 3'd2, B_INCR);
                total++;
                if (aw_ready_o !== 1'b0) begin
                    bad++; $display("FAIL b2b_full_ready: aw_ready=%b required 0", aw_ready_o);
                end
            end
            collect(12, 40);
        join
        total++;
        if (cap_n !== 12) begin bad++; $display("FAIL b2b_count: got %0d beats required 12", cap_n); end
        else begin
            total++;
            if (cap_cyc[11] - cap_cyc[0] !== 11) begin
                bad++;
                $display("FAIL b2b_no_bubble: span=%0d cycles required 11", cap_cyc[11] - cap_cyc[0]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (cap_add[i] !== base[i / 4] + 32'(4 * (i % 4)) || cap_id[i] !== 6'(i / 4 + 1) ||
                cap_last[i] !== ((i % 4) == 3)) begin
                bad++;
                $display("FAIL b2b_beat%0d: add=%h id=%0d last=%b required add=%h id=%0d last=%b",
                         i, cap_add[i], cap_id[i], cap_last[i], base[i / 4] + 32'(4 * (i % 4)),
                         i / 4 + 1, ((i % 4) == 3));
            end
        end
        total++;
        if (busy_o !== 1'b0 || aw_ready_o !== 1'b1) begin
            bad++; $display("FAIL b2b_drain: busy=%b ready=%b required 0 1", busy_o, aw_ready_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        int w = 0;
        int req_seen = 0;
        trans_gnt_i = 1'b1;
        send_aw(6'h21, 32'h6000, 8'd7, 3'd2, B_INCR);
        send_aw(6'h22, 32'h7000, 8'd0, 3'd2, B_INCR);
        while (!(trans_req_o && trans_add_o == 32'h6004) && w < 20) begin cyc(); w++; end
        total++;
        if (trans_req_o !== 1'b1 || trans_add_o !== 32'h6004) begin
            bad++;
            $display("FAIL rst_mid_reach_beat2: req=%b add=%h required 1 00006004", trans_req_o, trans_add_o);
        end
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        total++;
        if (trans_req_o !== 1'b0 || busy_o !== 1'b0 || aw_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_after: req=%b busy=%b ready=%b required 0 0 1",
                     trans_req_o, busy_o, aw_ready_o);
        end
        for (int i = 0; i < 12; i++) begin
            if (trans_req_o) req_seen++;
            cyc();
        end
        total++;
        if (req_seen !== 0) begin
            bad++; $display("FAIL rst_mid_stale: %0d req cycles after reset required 0", req_seen);
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed_and_narrow();
        test_size_err();
        test_stall();
        test_back_to_back();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
